decode_ctrl: RTL and testbench

- ID-stage controller for the 16-bit pipelined CPU.
- Decodes the IF/ID instruction and drives the immediate-format select to the sign-extension unit.
- Registers the ID/EX control word, detects load-use hazards, sequences multi-cycle MUL in EX, handles flush and HALT.
- Sits between the IF/ID register and the EX stage; owns stall_if and the ID/EX valid bit.

---
 rtl/cpu_isa_pkg.sv | 23 ++
 rtl/instr_decode.sv | 66 ++++++
 rtl/decode_ctrl.sv | 98 +++++++++
 tb/tb_decode_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg: opcodes, immediate-format selects and the ID/EX control word for the 16-bit CPU
package cpu_isa_pkg;
   localparam logic [3:0] OP_ALU  = 4'h0;
   localparam logic [3:0] OP_ADDI = 4'h1;
   localparam logic [3:0] OP_LW   = 4'h2;
   localparam logic [3:0] OP_SW   = 4'h3;
   localparam logic [3:0] OP_BRZ  = 4'h4;
   localparam logic [3:0] OP_JMP  = 4'h5;
   localparam logic [3:0] OP_MUL  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;
   localparam logic [1:0] EXT_IMM8    = 2'd0;
   localparam logic [1:0] EXT_IMM4_HI = 2'd1;
   localparam logic [1:0] EXT_IMM4_LO = 2'd2;
   typedef struct packed {
      logic [3:0] opcode;
      logic [1:0] imm_sel;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
   } ctrl_t;
   typedef enum logic [1:0] {S_RUN, S_MULB, S_HALT} state_t;
endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational opcode table giving sources, destination, extender format and controls
module instr_decode
   import cpu_isa_pkg::*;
(
   input  logic [15:0] instr,
   output ctrl_t       ctrl,
   output logic [3:0]  rd,
   output logic [3:0]  src_a,
   output logic [3:0]  src_b,
   output logic        use_a,
   output logic        use_b,
   output logic        is_mul,
   output logic        is_halt,
   output logic        illegal
);
   logic has_rd;
   logic unused_c;
   assign src_a    = instr[11:8];
   assign src_b    = instr[7:4];
   assign is_mul   = instr[15:12] == OP_MUL;
   assign is_halt  = instr[15:12] == OP_HALT;
   assign unused_c = ^instr[3:0];
   always_comb begin
      ctrl        = '0;
      ctrl.opcode = instr[15:12];
      use_a       = 1'b0;
      use_b       = 1'b0;
      has_rd      = 1'b0;
      illegal     = 1'b0;
      case (instr[15:12])
         OP_ALU, OP_MUL: begin
            use_a          = 1'b1;
            use_b          = 1'b1;
            has_rd         = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OP_ADDI: begin
            use_a          = 1'b1;
            has_rd         = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         OP_LW: begin
            use_b          = 1'b1;
            has_rd         = 1'b1;
            ctrl.imm_sel   = EXT_IMM4_LO;
            ctrl.reg_write = 1'b1;
            ctrl.mem_read  = 1'b1;
         end
         OP_SW: begin
            use_a          = 1'b1;
            use_b          = 1'b1;
            ctrl.imm_sel   = EXT_IMM4_LO;
            ctrl.mem_write = 1'b1;
         end
         OP_BRZ: begin
            use_a          = 1'b1;
            ctrl.imm_sel   = EXT_IMM4_HI;
            ctrl.branch    = 1'b1;
         end
         OP_JMP:  ctrl.branch = 1'b1;
         OP_HALT: ctrl.imm_sel = EXT_IMM8;
         default: illegal = 1'b1;
      endcase
      rd = has_rd ? instr[11:8] : 4'd0;
   end
endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: ID-stage controller; registers the ID/EX control word, load-use stalls,
// multi-cycle MUL occupancy, flush and HALT freeze
module decode_ctrl
   import cpu_isa_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int REG_AW     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [15:0]       id_instr,
   input  logic              flush,
   output logic [1:0]        ex_sel,
   output logic              stall_if,
   output logic              ex_valid,
   output logic [3:0]        ex_opcode,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_branch,
   output logic [1:0]        ex_imm_sel,
   output logic              mul_busy,
   output logic              halted,
   output logic              illegal
);
   ctrl_t             dctl, ex_q;
   logic [3:0]        rd, src_a, src_b, cnt;
   logic              use_a, use_b, is_mul, is_halt, dec_ill, hazard, run, load;
   logic [REG_AW-1:0] rd_q;
   state_t            state;
   instr_decode u_dec (
      .instr   (id_instr),
      .ctrl    (dctl),
      .rd      (rd),
      .src_a   (src_a),
      .src_b   (src_b),
      .use_a   (use_a),
      .use_b   (use_b),
      .is_mul  (is_mul),
      .is_halt (is_halt),
      .illegal (dec_ill)
   );
   always_comb begin
      run      = state == S_RUN;
      hazard   = ex_valid & ex_q.mem_read & id_valid &
                 ((use_a & (rd_q == REG_AW'(src_a))) | (use_b & (rd_q == REG_AW'(src_b))));
      stall_if = !run | (hazard & !flush);
      load     = run & id_valid & !hazard & !flush & !dec_ill;
      ex_sel   = dctl.imm_sel;
   end
   // MULB lasts MUL_CYCLES-1 cycles; the final EX cycle of MUL runs in RUN so the next instruction loads behind it
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= S_RUN;
         cnt      <= 4'd0;
         ex_valid <= 1'b0;
         ex_q     <= '0;
         rd_q     <= '0;
         mul_busy <= 1'b0;
         halted   <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         illegal <= run & id_valid & dec_ill & !flush;
         if (run) begin
            ex_valid <= load;
            ex_q     <= load ? dctl : '0;
            rd_q     <= load ? REG_AW'(rd) : '0;
            if (load & is_mul) begin
               state    <= S_MULB;
               cnt      <= 4'(MUL_CYCLES - 1);
               mul_busy <= 1'b1;
            end
            if (load & is_halt) begin
               state  <= S_HALT;
               halted <= 1'b1;
            end
         end else if (state == S_MULB) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
               state    <= S_RUN;
               mul_busy <= 1'b0;
            end
         end else begin
            ex_valid <= 1'b0;
            ex_q     <= '0;
            rd_q     <= '0;
         end
      end
   assign ex_opcode    = ex_q.opcode;
   assign ex_rd        = rd_q;
   assign ex_reg_write = ex_q.reg_write;
   assign ex_mem_read  = ex_q.mem_read;
   assign ex_mem_write = ex_q.mem_write;
   assign ex_branch    = ex_q.branch;
   assign ex_imm_sel   = ex_q.imm_sel;
endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: directed vector table for single-cycle decode plus sequences for
// load-use, flush, MUL occupancy, HALT and reset
module tb_decode_ctrl;
   logic        clk = 1'b0, rst = 1'b1, id_valid = 1'b0, flush = 1'b0;
   logic [15:0] id_instr = 16'h0;
   logic [1:0]  ex_sel, ex_imm_sel;
   logic [3:0]  ex_opcode, ex_rd;
   logic        stall_if, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
   logic        mul_busy, halted, illegal;
   int          checks = 0, errors = 0;
   typedef struct {
      logic        vld;
      logic [15:0] instr;
      logic        fl;
      logic [1:0]  sel;
      logic        ev;
      logic [3:0]  op;
      logic [3:0]  rd;
      logic        rw, mr, mw, br, ill;
   } vec_t;
   vec_t tbl[12];
   always #5 clk = ~clk;
   decode_ctrl #(.MUL_CYCLES(4), .REG_AW(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_instr     (id_instr),
      .flush        (flush),
      .ex_sel       (ex_sel),
      .stall_if     (stall_if),
      .ex_valid     (ex_valid),
      .ex_opcode    (ex_opcode),
      .ex_rd        (ex_rd),
      .ex_reg_write (ex_reg_write),
      .ex_mem_read  (ex_mem_read),
      .ex_mem_write (ex_mem_write),
      .ex_branch    (ex_branch),
      .ex_imm_sel   (ex_imm_sel),
      .mul_busy     (mul_busy),
      .halted       (halted),
      .illegal      (illegal)
   );
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic v, input logic [15:0] i, input logic f);
      id_valid = v;
      id_instr = i;
      flush    = f;
   endtask
   initial begin
      tbl[0]  = '{1'b1, 16'h0321, 1'b0, 2'd0, 1'b1, 4'h0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 16'h1A7F, 1'b0, 2'd0, 1'b1, 4'h1, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 16'h2315, 1'b0, 2'd2, 1'b1, 4'h2, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 16'h3125, 1'b0, 2'd2, 1'b1, 4'h3, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 16'h42D0, 1'b0, 2'd1, 1'b1, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 16'h5123, 1'b0, 2'd0, 1'b1, 4'h5, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 16'hA123, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 16'hA123, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 16'h6FFF, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 16'h0321, 1'b1, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 16'hB000, 1'b1, 2'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 16'h2315, 1'b0, 2'd2, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      #2;
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_halted", halted, 0);
      chk("rst_mul_busy", mul_busy, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_stall", stall_if, 0);
      chk("rst_reg_write", ex_reg_write, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      tick;
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].vld, tbl[i].instr, tbl[i].fl);
         #3;
         chk($sformatf("v%0d_ex_sel", i), ex_sel, tbl[i].sel);
         chk($sformatf("v%0d_stall", i), stall_if, 0);
         tick;
         chk($sformatf("v%0d_ex_valid", i), ex_valid, tbl[i].ev);
         chk($sformatf("v%0d_opcode", i), ex_opcode, tbl[i].op);
         if (!tbl[i].ev || tbl[i].rw) chk($sformatf("v%0d_rd", i), ex_rd, tbl[i].rd);
         chk($sformatf("v%0d_reg_write", i), ex_reg_write, tbl[i].rw);
         chk($sformatf("v%0d_mem_read", i), ex_mem_read, tbl[i].mr);
         chk($sformatf("v%0d_mem_write", i), ex_mem_write, tbl[i].mw);
         chk($sformatf("v%0d_branch", i), ex_branch, tbl[i].br);
         chk($sformatf("v%0d_imm_sel", i), ex_imm_sel, tbl[i].ev ? tbl[i].sel : 2'd0);
         chk($sformatf("v%0d_illegal", i), illegal, tbl[i].ill);
         drive(1'b0, 16'h0, 1'b0);
         tick;
         chk($sformatf("v%0d_illegal_clr", i), illegal, 0);
         chk($sformatf("v%0d_bubble", i), ex_valid, 0);
      end
      drive(1'b1, 16'h2315, 1'b0);
      #3 chk("lu_sel", ex_sel, 2);
      tick;
      drive(1'b1, 16'h0321, 1'b0);
      #3 chk("lu_stall", stall_if, 1);
      tick;
      chk("lu_bubble", ex_valid, 0);
      chk("lu_bubble_rw", ex_reg_write, 0);
      chk("lu_stall_once", stall_if, 0);
      tick;
      chk("lu_alu_valid", ex_valid, 1);
      chk("lu_alu_op", ex_opcode, 4'h0);
      chk("lu_alu_rd", ex_rd, 4'h3);
      drive(1'b0, 16'h0, 1'b0);
      tick;
      drive(1'b1, 16'h2315, 1'b0);
      tick;
      drive(1'b1, 16'h0321, 1'b1);
      #3 chk("fl_stall", stall_if, 0);
      tick;
      chk("fl_bubble", ex_valid, 0);
      chk("fl_illegal", illegal, 0);
      drive(1'b1, 16'h1400, 1'b0);
      #3 chk("fl_next_stall", stall_if, 0);
      tick;
      chk("fl_next_valid", ex_valid, 1);
      chk("fl_next_op", ex_opcode, 4'h1);
      chk("fl_next_rd", ex_rd, 4'h4);
      drive(1'b0, 16'h0, 1'b0);
      tick;
      drive(1'b1, 16'h8450, 1'b0);
      tick;
      drive(1'b1, 16'h1600, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("mul%0d_busy", k), mul_busy, 1);
         chk($sformatf("mul%0d_stall", k), stall_if, 1);
         chk($sformatf("mul%0d_valid", k), ex_valid, 1);
         chk($sformatf("mul%0d_op", k), ex_opcode, 4'h8);
         tick;
      end
      chk("mul_last_busy", mul_busy, 0);
      chk("mul_last_stall", stall_if, 0);
      chk("mul_last_valid", ex_valid, 1);
      chk("mul_last_op", ex_opcode, 4'h8);
      tick;
      chk("mul_next_valid", ex_valid, 1);
      chk("mul_next_op", ex_opcode, 4'h1);
      chk("mul_next_rd", ex_rd, 4'h6);
      drive(1'b1, 16'h8450, 1'b0);
      tick;
      drive(1'b0, 16'h0, 1'b0);
      chk("mrst_busy_pre", mul_busy, 1);
      rst = 1'b1;
      #1;
      chk("mrst_busy", mul_busy, 0);
      chk("mrst_valid", ex_valid, 0);
      chk("mrst_stall", stall_if, 0);
      rst = 1'b0;
      tick;
      chk("mrst_after_busy", mul_busy, 0);
      drive(1'b1, 16'hF000, 1'b0);
      tick;
      drive(1'b1, 16'h1700, 1'b0);
      chk("halt_halted", halted, 1);
      chk("halt_valid", ex_valid, 1);
      chk("halt_op", ex_opcode, 4'hF);
      chk("halt_stall", stall_if, 1);
      for (int k = 0; k < 4; k++) begin
         tick;
         chk($sformatf("halt%0d_halted", k), halted, 1);
         chk($sformatf("halt%0d_stall", k), stall_if, 1);
         chk($sformatf("halt%0d_valid", k), ex_valid, 0);
      end
      rst = 1'b1;
      #1;
      chk("hrst_halted", halted, 0);
      chk("hrst_stall", stall_if, 0);
      chk("hrst_valid", ex_valid, 0);
      chk("hrst_op", ex_opcode, 4'h0);
      rst = 1'b0;
      #1 chk("hrst_sel", ex_sel, 0);
      tick;
      chk("hrst_addi_valid", ex_valid, 1);
      chk("hrst_addi_op", ex_opcode, 4'h1);
      chk("hrst_addi_rd", ex_rd, 4'h7);
      chk("hrst_addi_rw", ex_reg_write, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
